serial_operand_feeder: RTL and testbench

- Upstream stage of the serial adder datapath.
- Accepts operand pairs as parallel words over a valid/ready handshake.
- Emits them LSB-first, one bit pair per cycle, with vld/last framing for the downstream serial adder.
- One-entry pending buffer allows back-to-back transactions with no bubble between a `last` bit and the next word's bit 0.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/operand_hold_reg.sv | 57 +++++
 rtl/serial_operand_feeder.sv | 144 ++++++++++++++
 tb/tb_serial_operand_feeder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial adder datapath.
//   SERIAL_W       default operand width
//   feeder_state_t shift/count FSM state encoding
//   clamp_len()    limits a requested bit count to the operand width
package serial_pkg;

  localparam int SERIAL_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

  // len is "bits minus one"; anything past the top bit of the word is capped.
  function automatic int clamp_len(input int len, input int w);
    int res;
    if (len > (w - 1)) begin
      res = w - 1;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_hold_reg.sv
// operand_hold_reg: one-entry holding buffer for an operand pair plus its
// (already clamped) length, used as the pending slot behind the shifter.
//   clk, clr        clock, async active-high reset
//   push            write din_* into the slot (caller guarantees !full)
//   pop             release the slot (caller guarantees full)
//   din_a/b/len     payload in
//   full            slot occupied (acts as out_valid; !full is the in_ready)
//   dout_a/b/len    payload out
module operand_hold_reg
  import serial_pkg::*;
#(
  parameter int W     = SERIAL_W,
  parameter int LEN_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din_a,
  input  logic [W-1:0]     din_b,
  input  logic [LEN_W-1:0] din_len,
  output logic             full,
  output logic [W-1:0]     dout_a,
  output logic [W-1:0]     dout_b,
  output logic [LEN_W-1:0] dout_len
);

  logic             pfull_r;
  logic [W-1:0]     pa_r;
  logic [W-1:0]     pb_r;
  logic [LEN_W-1:0] plen_r;

  // Slot occupancy and payload capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pfull_r <= 1'b0;
      pa_r    <= '0;
      pb_r    <= '0;
      plen_r  <= '0;
    end else if (push) begin
      pfull_r <= 1'b1;
      pa_r    <= din_a;
      pb_r    <= din_b;
      plen_r  <= din_len;
    end else if (pop) begin
      pfull_r <= 1'b0;
    end else begin
      pfull_r <= pfull_r;
    end
  end

  assign full     = pfull_r;
  assign dout_a   = pa_r;
  assign dout_b   = pb_r;
  assign dout_len = plen_r;

endmodule

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: takes parallel operand pairs over valid/ready and
// streams them LSB-first, one bit pair per cycle, framed by vld/last.
//   clk, clr         clock, async active-high reset
//   in_valid/ready   upstream handshake (in_ready depends only on state)
//   in_a, in_b       parallel operands
//   in_len           bits to send minus one, clamped to W-1
//   stall            downstream bubble: hides vld and freezes the shifter
//   vld, a, b, last  serial bit pair and end-of-transaction marker
//   busy             shifting or pending slot occupied
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int W     = SERIAL_W,
  parameter int LEN_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [LEN_W-1:0] in_len,
  input  logic             stall,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last,
  output logic             busy
);

  feeder_state_t    state_r;
  logic [W-1:0]     sa_r;
  logic [W-1:0]     sb_r;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] len_r;

  logic             pfull_s;
  logic [W-1:0]     pa_s;
  logic [W-1:0]     pb_s;
  logic [LEN_W-1:0] plen_s;

  logic             vld_s;
  logic             last_s;
  logic             accept_s;
  logic             load_direct_s;
  logic             push_s;
  logic             pop_s;
  logic [LEN_W-1:0] len_in_s;

  // Handshake and routing decisions for the current cycle.
  always_comb begin
    vld_s    = (state_r == SHIFT) && !stall;
    last_s   = vld_s && (cnt_r == len_r);
    accept_s = in_valid && !pfull_s;
    // A word accepted while idle, or on the edge that retires the last bit
    // (slot necessarily empty, since accept needs !pfull), bypasses the slot.
    if (accept_s && ((state_r == IDLE) || last_s)) begin
      load_direct_s = 1'b1;
    end else begin
      load_direct_s = 1'b0;
    end
    push_s   = accept_s && !load_direct_s;
    pop_s    = last_s && pfull_s;
    len_in_s = LEN_W'(clamp_len(int'(in_len), W));
  end

  operand_hold_reg #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_pending (
    .clk      (clk),
    .clr      (clr),
    .push     (push_s),
    .pop      (pop_s),
    .din_a    (in_a),
    .din_b    (in_b),
    .din_len  (len_in_s),
    .full     (pfull_s),
    .dout_a   (pa_s),
    .dout_b   (pb_s),
    .dout_len (plen_s)
  );

  // Shift/count FSM: load, shift on each visible bit, reload or idle at last.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      cnt_r   <= '0;
      len_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_direct_s) begin
            sa_r    <= in_a;
            sb_r    <= in_b;
            len_r   <= len_in_s;
            cnt_r   <= '0;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (last_s) begin
            if (pfull_s) begin
              sa_r    <= pa_s;
              sb_r    <= pb_s;
              len_r   <= plen_s;
              cnt_r   <= '0;
              state_r <= SHIFT;
            end else if (load_direct_s) begin
              sa_r    <= in_a;
              sb_r    <= in_b;
              len_r   <= len_in_s;
              cnt_r   <= '0;
              state_r <= SHIFT;
            end else begin
              state_r <= IDLE;
            end
          end else if (vld_s) begin
            sa_r  <= sa_r >> 1;
            sb_r  <= sb_r >> 1;
            cnt_r <= cnt_r + LEN_W'(1);
          end else begin
            state_r <= SHIFT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign vld      = vld_s;
  assign last     = last_s;
  assign a        = sa_r[0];
  assign b        = sb_r[0];
  assign in_ready = !pfull_s;
  assign busy     = (state_r == SHIFT) || pfull_s;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb_serial_operand_feeder: directed, table-driven bench for the serial
// operand feeder (W=8), plus hand-written back-to-back, stall and reset cases.
module tb_serial_operand_feeder;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_len;
  logic       stall;
  logic       vld;
  logic       a;
  logic       b;
  logic       last;
  logic       busy;

  int n_checks;
  int n_fail;

  serial_operand_feeder #(.W(8), .LEN_W(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_len   (in_len),
    .stall    (stall),
    .vld      (vld),
    .a        (a),
    .b        (b),
    .last     (last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ia;
    logic [7:0] ib;
    logic [3:0] len;   // requested length; driven through the 3-bit port
    logic [7:0] ea;    // bit i = expected a on vld cycle i
    logic [7:0] eb;
    int         n;     // expected number of vld cycles
  } vec_t;

  vec_t vecs[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq_a;
    logic [7:0] seq_b;
    logic [7:0] seq_last;
    logic [7:0] seq_rdy;
    logic [5:0] st_vld;
    logic [5:0] st_a;
    logic [5:0] st_last;
    logic [5:0] st_stall;

    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b1;
    in_valid = 1'b0;
    in_a     = 8'h00;
    in_b     = 8'h00;
    in_len   = 3'd0;
    stall    = 1'b0;

    vecs[0] = '{ia: 8'hA5, ib: 8'h3C, len: 4'd7,  ea: 8'hA5, eb: 8'h3C, n: 8};
    vecs[1] = '{ia: 8'h01, ib: 8'h01, len: 4'd0,  ea: 8'h01, eb: 8'h01, n: 1};
    vecs[2] = '{ia: 8'hF3, ib: 8'h5C, len: 4'd3,  ea: 8'h03, eb: 8'h0C, n: 4};
    vecs[3] = '{ia: 8'h81, ib: 8'h7E, len: 4'd15, ea: 8'h81, eb: 8'h7E, n: 8};
    vecs[4] = '{ia: 8'hFF, ib: 8'h00, len: 4'd4,  ea: 8'h1F, eb: 8'h00, n: 5};

    // Reset state, observed while clr is held.
    #2;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_vld", vld, 1'b0);
    chk1("rst_last", last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_a", a, 1'b0);
    chk1("rst_b", b, 1'b0);
    next_cyc();
    clr = 1'b0;
    next_cyc();

    // Table-driven single transactions.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_a     = vecs[k].ia;
      in_b     = vecs[k].ib;
      in_len   = 3'(vecs[k].len);
      #1;
      chk1($sformatf("v%0d_ready", k), in_ready, 1'b1);
      chk1($sformatf("v%0d_idle_vld", k), vld, 1'b0);
      next_cyc();
      in_valid = 1'b0;
      for (int i = 0; i < vecs[k].n; i++) begin
        #1;
        chk1($sformatf("v%0d_c%0d_vld", k, i), vld, 1'b1);
        chk1($sformatf("v%0d_c%0d_a", k, i), a, vecs[k].ea[i]);
        chk1($sformatf("v%0d_c%0d_b", k, i), b, vecs[k].eb[i]);
        chk1($sformatf("v%0d_c%0d_last", k, i), last, (i == vecs[k].n - 1));
        next_cyc();
      end
      #1;
      chk1($sformatf("v%0d_end_vld", k), vld, 1'b0);
      chk1($sformatf("v%0d_end_busy", k), busy, 1'b0);
      next_cyc();
    end

    // Back-to-back via the pending slot: w1 = 1101 (LSB first 1,0,1,1),
    // w2 = 0110 with b all ones; 8 contiguous vld cycles.
    seq_a    = 8'h6D;
    seq_b    = 8'hF0;
    seq_last = 8'h88;
    seq_rdy  = 8'hF1;
    in_valid = 1'b1;
    in_a     = 8'h0D;
    in_b     = 8'h00;
    in_len   = 3'd3;
    next_cyc();
    in_valid = 1'b1;
    in_a     = 8'h06;
    in_b     = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1($sformatf("b2b_c%0d_ready", i), in_ready, seq_rdy[i]);
      chk1($sformatf("b2b_c%0d_vld", i), vld, 1'b1);
      chk1($sformatf("b2b_c%0d_a", i), a, seq_a[i]);
      chk1($sformatf("b2b_c%0d_b", i), b, seq_b[i]);
      chk1($sformatf("b2b_c%0d_last", i), last, seq_last[i]);
      next_cyc();
      in_valid = 1'b0;
    end
    #1;
    chk1("b2b_end_vld", vld, 1'b0);
    chk1("b2b_end_busy", busy, 1'b0);
    next_cyc();

    // Direct load on the last edge with an empty slot: w1 len 1, w2 len 0.
    in_valid = 1'b1;
    in_a     = 8'h01;
    in_b     = 8'h00;
    in_len   = 3'd1;
    next_cyc();
    in_valid = 1'b0;
    #1;
    chk1("dl_c0_vld", vld, 1'b1);
    chk1("dl_c0_a", a, 1'b1);
    chk1("dl_c0_last", last, 1'b0);
    next_cyc();
    in_valid = 1'b1;
    in_a     = 8'h01;
    in_b     = 8'h01;
    in_len   = 3'd0;
    #1;
    chk1("dl_c1_vld", vld, 1'b1);
    chk1("dl_c1_a", a, 1'b0);
    chk1("dl_c1_last", last, 1'b1);
    next_cyc();
    in_valid = 1'b0;
    #1;
    chk1("dl_c2_vld", vld, 1'b1);
    chk1("dl_c2_a", a, 1'b1);
    chk1("dl_c2_b", b, 1'b1);
    chk1("dl_c2_last", last, 1'b1);
    next_cyc();
    #1;
    chk1("dl_end_vld", vld, 1'b0);
    next_cyc();

    // Stall on cycles 2-3 of a 4-bit transaction carrying 1011.
    st_stall = 6'b000110;
    st_vld   = 6'b111001;
    st_a     = 6'b101111;
    st_last  = 6'b100000;
    in_valid = 1'b1;
    in_a     = 8'h0B;
    in_b     = 8'h00;
    in_len   = 3'd3;
    next_cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stall = st_stall[i];
      #1;
      chk1($sformatf("st_c%0d_vld", i + 1), vld, st_vld[i]);
      chk1($sformatf("st_c%0d_a", i + 1), a, st_a[i]);
      chk1($sformatf("st_c%0d_last", i + 1), last, st_last[i]);
      next_cyc();
    end
    stall = 1'b0;
    #1;
    chk1("st_end_vld", vld, 1'b0);
    chk1("st_end_busy", busy, 1'b0);
    next_cyc();

    // clr on bit 3 with a pending word queued behind.
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_len   = 3'd7;
    next_cyc();
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    next_cyc();
    in_valid = 1'b0;
    #1;
    chk1("clr_pre_ready", in_ready, 1'b0);
    next_cyc();
    #1;
    chk1("clr_pre_vld", vld, 1'b1);
    #1;
    clr = 1'b1;
    #1;
    chk1("clr_vld_async", vld, 1'b0);
    chk1("clr_last_async", last, 1'b0);
    next_cyc();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1($sformatf("clr_post%0d_vld", i), vld, 1'b0);
      chk1($sformatf("clr_post%0d_busy", i), busy, 1'b0);
      chk1($sformatf("clr_post%0d_ready", i), in_ready, 1'b1);
      next_cyc();
    end

    // Fresh single-bit transaction after the reset.
    in_valid = 1'b1;
    in_a     = 8'h00;
    in_b     = 8'h01;
    in_len   = 3'd0;
    next_cyc();
    in_valid = 1'b0;
    #1;
    chk1("after_clr_vld", vld, 1'b1);
    chk1("after_clr_a", a, 1'b0);
    chk1("after_clr_b", b, 1'b1);
    chk1("after_clr_last", last, 1'b1);
    next_cyc();
    #1;
    chk1("after_clr_end_vld", vld, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
